dac_pacer: RTL

DAC_PACER -- requirements
Module: dac_pacer

---
 rtl/dac_pacer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dac_pacer.sv
// Paced DAC playout: samples are buffered in a FIFO, primed, then popped to the DAC once every div+1 clocks.
// Define DAC_PACER_HOLD_EN to keep the last played sample on dac_data after the stream ends.

module dac_pacer #(
    parameter int                DWIDTH        = 32,
    parameter int                DEPTH         = 256,
    parameter int                PRIME_LEVEL   = 16,
    parameter int                PRIME_TIMEOUT = 1024,
    parameter logic [DWIDTH-1:0] IDLE_VALUE    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            div,
    input  logic [DWIDTH-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic [DWIDTH-1:0]      dac_data,
    output logic                   dac_strobe,
    output logic [$clog2(DEPTH):0] level,
    output logic                   running,
    output logic                   overflow,
    input  logic                   clear_flags
);

    localparam int                AW      = $clog2(DEPTH);
    localparam int                PCW     = $clog2(PRIME_TIMEOUT) + 1;
    localparam logic [AW:0]       L_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       L_PRIME = (AW + 1)'(PRIME_LEVEL);
    localparam logic [PCW-1:0]    L_TMO   = PCW'(PRIME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [DWIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_level;
    logic [PCW-1:0]      r_prime_cnt;
    logic [15:0]         r_tick_cnt;
    logic [15:0]         r_period;
    logic [DWIDTH-1:0]   r_dac_data;
    logic                r_dac_strobe;
    logic                r_overflow;
    logic                w_full;
    logic                w_tick;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;
    logic                w_run_entry;

    // Assertion is immediate; release is retimed to clk so every flop leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_full      = (r_level == L_DEPTH);
    assign w_tick      = (r_state == RUN) && (r_tick_cnt == r_period);
    assign w_pop       = w_tick && (r_level != '0);
    assign w_wr        = s_axis_tvalid && (!w_full || w_pop);
    assign w_drop      = s_axis_tvalid && w_full && !w_pop;
    assign w_run_entry = (r_state != RUN) && (w_state_nxt == RUN);

    // NOTE: storage has no reset so it can map onto block RAM; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr) begin
                    w_state_nxt = PRIME;
                end
            end
            PRIME: begin
                if ((r_level >= L_PRIME) || ((r_prime_cnt == L_TMO) && (r_level != '0))) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_tick && (r_level == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The prime counter idles at zero outside PRIME and saturates at the timeout value.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prime_cnt <= '0;
        end else if (r_state != PRIME) begin
            r_prime_cnt <= '0;
        end else if (r_prime_cnt != L_TMO) begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
        end
    end

    // Tick fires when the count reaches the period latched at the last reload; entry preloads a match.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tick_cnt <= '0;
            r_period   <= '0;
        end else if (w_run_entry) begin
            r_tick_cnt <= div;
            r_period   <= div;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_period   <= div;
        end else if (r_state == RUN) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dac_data   <= IDLE_VALUE;
            r_dac_strobe <= 1'b0;
        end else if (w_pop) begin
            r_dac_data   <= r_mem[r_rd_ptr];
            r_dac_strobe <= 1'b1;
        end else begin
            r_dac_strobe <= 1'b0;
`ifdef DAC_PACER_HOLD_EN
            r_dac_data   <= r_dac_data;
`else
            if (r_state == IDLE) begin
                r_dac_data <= IDLE_VALUE;
            end
`endif
        end
    end

    // A drop in the same cycle as clear_flags leaves the flag set.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_flags) begin
            r_overflow <= 1'b0;
        end
    end

    assign dac_data   = r_dac_data;
    assign dac_strobe = r_dac_strobe;
    assign level      = r_level;
    assign running    = (r_state == RUN);
    assign overflow   = r_overflow;

endmodule
